mult_seq_param: RTL and testbench

- Parametrised sequential shift-and-add multiplier; next generation of the team's 4-bit multiplier FSM.
- Operand width and product width are generic.
- Adds a signed (two's-complement) mode, a busy flag, and correct overflow against the configured product width.
- Used as the multiply unit of the lab datapath, driven by an init pulse and polled via done/busy.

---
 rtl/mult_seq_param.sv | 125 ++++++++++++
 tb/tb_mult_seq_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// Sequential shift-and-add multiplier, generic operand/product width.
// Signed mode works on magnitudes and fixes the sign at the end.
module mult_seq_param #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] MD,
  input  logic [WIDTH-1:0] MR,
  output logic [OUT_W-1:0] PP,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             zero
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADD,
    SHIFT,
    SIGN,
    DONE
  } state_t;

  state_t            st;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic              smode;

  logic [WIDTH-1:0]  md_abs;
  logic [WIDTH-1:0]  mr_abs;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     hi_u;
  logic [PW-1:0]     hi_s;
  logic              ovf_c;

  // Operand magnitudes; -2^(W-1) maps onto itself, read as unsigned.
  always_comb begin
    md_abs = MD;
    mr_abs = MR;
    if (signed_mode && MD[WIDTH-1]) md_abs = '0 - MD;
    if (signed_mode && MR[WIDTH-1]) mr_abs = '0 - MR;
  end

  // Signed product and its fit against the configured output width.
  always_comb begin
    prod  = neg ? ('0 - acc) : acc;
    hi_u  = prod >> OUT_W;
    hi_s  = PW'($signed(prod) >>> (OUT_W - 1));
    ovf_c = smode ? !((hi_s == '0) || (&hi_s)) : (|hi_u);
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      smode    <= 1'b0;
      PP       <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (init) begin
            st       <= CHECK;
            smode    <= signed_mode;
            a        <= md_abs;
            b        <= mr_abs;
            neg      <= signed_mode & (MD[WIDTH-1] ^ MR[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CHECK: begin
          st <= b[0] ? ADD : SHIFT;
        end
        ADD: begin
          acc <= acc + ({{WIDTH{1'b0}}, a} << cnt);
          st  <= SHIFT;
        end
        SHIFT: begin
          b   <= b >> 1;
          cnt <= cnt + 1'b1;
          st  <= (cnt == LAST) ? SIGN : CHECK;
        end
        SIGN: begin
          acc      <= prod;
          PP       <= prod[OUT_W-1:0];
          overflow <= ovf_c;
          zero     <= (acc == '0);
          done     <= 1'b1;
          st       <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: three instances (OUT_W 8/6/7)
// share stimulus; a monitor checks each result as done rises.
module tb_mult_seq_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic       signed_mode = 1'b0;
  logic [3:0] md = '0;
  logic [3:0] mr = '0;

  logic [7:0] pp8;
  logic [5:0] pp6;
  logic [6:0] pp7;
  logic done, busy, ovf8, zero;
  logic done6, busy6, ovf6, zero6;
  logic done7, busy7, ovf7, zero7;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(4), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .init(init), .signed_mode(signed_mode),
    .MD(md), .MR(mr), .PP(pp8), .done(done), .busy(busy),
    .overflow(ovf8), .zero(zero)
  );

  mult_seq_param #(.WIDTH(4), .OUT_W(6)) dut6 (
    .clk(clk), .rst(rst), .init(init), .signed_mode(signed_mode),
    .MD(md), .MR(mr), .PP(pp6), .done(done6), .busy(busy6),
    .overflow(ovf6), .zero(zero6)
  );

  mult_seq_param #(.WIDTH(4), .OUT_W(7)) dut7 (
    .clk(clk), .rst(rst), .init(init), .signed_mode(signed_mode),
    .MD(md), .MR(mr), .PP(pp7), .done(done7), .busy(busy7),
    .overflow(ovf7), .zero(zero7)
  );

  typedef struct {
    logic [7:0] pp;
    logic       ovf;
    logic       zero;
    logic       alt;
    logic [5:0] pp6;
    logic       ovf6;
    logic [6:0] pp7;
    logic       ovf7;
    int         t0;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  // Monitor: pop and compare on each rising done of the main instance.
  always @(negedge clk) begin
    if (!rst && done && !done_q) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pp", 32'(pp8), 32'(e.pp));
        chk("overflow", 32'(ovf8), 32'(e.ovf));
        chk("zero", 32'(zero), 32'(e.zero));
        chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
        if (e.alt) begin
          chk("pp_w6", 32'(pp6), 32'(e.pp6));
          chk("ovf_w6", 32'(ovf6), 32'(e.ovf6));
          chk("zero_w6", 32'(zero6), 32'(e.zero));
          chk("pp_w7", 32'(pp7), 32'(e.pp7));
          chk("ovf_w7", 32'(ovf7), 32'(e.ovf7));
        end
      end
    end
    done_q = done;
  end

  task automatic start(input logic m, input logic [3:0] a,
                       input logic [3:0] b, output int t0);
    @(negedge clk);
    signed_mode = m;
    md = a;
    mr = b;
    init = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic push(input logic [7:0] p, input logic o, input logic z,
                      input int t0, input int lat);
    exp_t e;
    e = '{pp: p, ovf: o, zero: z, alt: 1'b0, pp6: '0, ovf6: 1'b0,
          pp7: '0, ovf7: 1'b0, t0: t0, lat: lat};
    q.push_back(e);
  endtask

  task automatic push_alt(input logic [7:0] p, input logic o,
                          input logic [5:0] p6, input logic o6,
                          input logic [6:0] p7, input logic o7,
                          input int t0, input int lat);
    exp_t e;
    e = '{pp: p, ovf: o, zero: 1'b0, alt: 1'b1, pp6: p6, ovf6: o6,
          pp7: p7, ovf7: o7, t0: t0, lat: lat};
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) return;
    end
    chk("timeout", 32'd1, 32'd0);
    q.delete();
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 200 && cyc < c; i++) @(negedge clk);
  endtask

  int t;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pp", 32'(pp8), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    start(1'b0, 4'd13, 4'd11, t);
    push(8'h8F, 1'b0, 1'b0, t, 13);
    wait_cyc(t + 12);
    chk("busy_at_done", 32'(busy), 32'd1);
    wait_cyc(t + 13);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_sticky", 32'(done), 32'd1);
    wait_idle();

    start(1'b1, 4'b1101, 4'b0101, t);
    push(8'hF1, 1'b0, 1'b0, t, 12);
    wait_idle();

    start(1'b1, 4'b1000, 4'b1000, t);
    push_alt(8'h40, 1'b0, 6'd0, 1'b1, 7'h40, 1'b1, t, 11);
    wait_idle();

    start(1'b0, 4'd15, 4'd15, t);
    push_alt(8'hE1, 1'b0, 6'd33, 1'b1, 7'd97, 1'b1, t, 14);
    wait_idle();

    start(1'b0, 4'd9, 4'd0, t);
    push(8'h00, 1'b0, 1'b1, t, 10);
    wait_idle();

    start(1'b0, 4'd6, 4'd5, t);
    push(8'h1E, 1'b0, 1'b0, t, 12);
    repeat (2) @(negedge clk);
    signed_mode = 1'b1;
    md = 4'd7;
    mr = 4'd7;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_idle();

    start(1'b0, 4'd9, 4'd9, t);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_pp", 32'(pp8), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    start(1'b0, 4'd7, 4'd7, t);
    push(8'h31, 1'b0, 1'b0, t, 13);
    wait_idle();

    @(negedge clk);
    signed_mode = 1'b0;
    md = 4'd3;
    mr = 4'd2;
    init = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    push(8'h06, 1'b0, 1'b0, t, 11);
    push(8'h06, 1'b0, 1'b0, t + 12, 11);
    push(8'h06, 1'b0, 1'b0, t + 24, 11);
    wait_cyc(t + 12);
    chk("reaccept1_done", 32'(done), 32'd0);
    chk("reaccept1_busy", 32'(busy), 32'd1);
    wait_cyc(t + 24);
    chk("reaccept2_done", 32'(done), 32'd0);
    chk("reaccept2_busy", 32'(busy), 32'd1);
    wait_cyc(t + 34);
    init = 1'b0;
    wait_idle();
    chk("held_all_done", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
